// File: rtl/flag_pattern_matcher.sv
// flag_pattern_matcher: history-window ALU flag matcher against NUM_PAT mask/value patterns.
// Define FLAG_PATTERN_COUNTER_EN to build the saturating anomaly counter; otherwise anomaly_count is 0.
module flag_pattern_matcher #(
  parameter int FLAG_W     = 4,
  parameter int HIST_DEPTH = 4,
  parameter int NUM_PAT    = 4,
  parameter int CNT_W      = 16,
  localparam int WIN_W     = FLAG_W*HIST_DEPTH,
  localparam int PIDX_W    = $clog2(NUM_PAT)
)(
  input  logic               clk,
  input  logic               reset,
  input  logic               flags_valid,
  input  logic [FLAG_W-1:0]  flags_in,
  input  logic               cfg_we,
  input  logic [PIDX_W-1:0]  cfg_idx,
  input  logic               cfg_en,
  input  logic [WIN_W-1:0]   cfg_mask,
  input  logic [WIN_W-1:0]   cfg_value,
  input  logic               status_clr,
  output logic [NUM_PAT-1:0] match_vec,
  output logic               anomaly_detected_out,
  output logic [NUM_PAT-1:0] sticky_status,
  output logic [CNT_W-1:0]   anomaly_count,
  output logic               hist_full
);
  localparam int FILL_W = $clog2(HIST_DEPTH+1);
  localparam logic [FILL_W-1:0] WARM = FILL_W'(HIST_DEPTH-1);
  localparam logic [FILL_W-1:0] FULL = FILL_W'(HIST_DEPTH);
  logic [WIN_W-1:0]   hist_q, hist_d, win;
  logic [FILL_W-1:0]  fill_q, fill_d;
  logic               full_q;
  logic [NUM_PAT-1:0] en_q, match_q, match_d, sticky_q, sticky_d;
  logic [WIN_W-1:0]   mask_q [NUM_PAT];
  logic [WIN_W-1:0]   value_q [NUM_PAT];
  logic               any_q, cfg_hit;
  assign win      = {hist_q[WIN_W-FLAG_W-1:0], flags_in};
  assign cfg_hit  = cfg_we && (32'(cfg_idx) < NUM_PAT);
  assign hist_d   = flags_valid ? win : hist_q;
  assign fill_d   = (flags_valid && fill_q != FULL) ? fill_q + 1'b1 : fill_q;
  assign sticky_d = (status_clr ? '0 : sticky_q) | match_d;
  // Patterns are compared with the configuration held before any same-cycle write.
  always_comb begin
    match_d = '0;
    for (int p = 0; p < NUM_PAT; p++)
      match_d[p] = flags_valid && (fill_q >= WARM) && en_q[p] &&
                   (((win ^ value_q[p]) & mask_q[p]) == '0);
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      hist_q   <= '0;
      fill_q   <= '0;
      full_q   <= 1'b0;
      match_q  <= '0;
      any_q    <= 1'b0;
      sticky_q <= '0;
      en_q     <= '0;
      for (int p = 0; p < NUM_PAT; p++) begin
        mask_q[p]  <= '0;
        value_q[p] <= '0;
      end
    end else begin
      hist_q   <= hist_d;
      fill_q   <= fill_d;
      full_q   <= (fill_d == FULL);
      match_q  <= match_d;
      any_q    <= |match_d;
      sticky_q <= sticky_d;
      if (cfg_hit) begin
        en_q[cfg_idx]    <= cfg_en;
        mask_q[cfg_idx]  <= cfg_mask;
        value_q[cfg_idx] <= cfg_value;
      end
    end
  end
`ifdef FLAG_PATTERN_COUNTER_EN
  logic [CNT_W-1:0] cnt_q, cnt_d;
  // A match in the clearing cycle restarts the count at one.
  assign cnt_d = (|match_d) ? (status_clr ? CNT_W'(1) : (&cnt_q ? cnt_q : cnt_q + 1'b1))
                            : (status_clr ? '0 : cnt_q);
  always_ff @(posedge clk) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end
  assign anomaly_count = cnt_q;
`else
  assign anomaly_count = '0;
`endif
  assign match_vec            = match_q;
  assign anomaly_detected_out = any_q;
  assign sticky_status        = sticky_q;
  assign hist_full            = full_q;
endmodule

// File: tb/tb_flag_pattern_matcher.sv
// tb_flag_pattern_matcher: scoreboard bench for flag_pattern_matcher with a behavioural history/pattern model.
module tb_flag_pattern_matcher;
  localparam int FW = 4, HD = 4, NP = 4, CW = 4, WW = FW*HD, PW = 2;
  logic          clk = 1'b0, reset = 1'b1, flags_valid = 1'b0, cfg_we = 1'b0, cfg_en = 1'b0, status_clr = 1'b0;
  logic [FW-1:0] flags_in = '0;
  logic [PW-1:0] cfg_idx = '0;
  logic [WW-1:0] cfg_mask = '0, cfg_value = '0;
  logic [NP-1:0] match_vec, sticky_status;
  logic          anomaly_detected_out, hist_full;
  logic [CW-1:0] anomaly_count;
  always #5 clk = ~clk;
  flag_pattern_matcher #(.FLAG_W(FW), .HIST_DEPTH(HD), .NUM_PAT(NP), .CNT_W(CW)) dut (
    .clk(clk), .reset(reset), .flags_valid(flags_valid), .flags_in(flags_in),
    .cfg_we(cfg_we), .cfg_idx(cfg_idx), .cfg_en(cfg_en), .cfg_mask(cfg_mask), .cfg_value(cfg_value),
    .status_clr(status_clr), .match_vec(match_vec), .anomaly_detected_out(anomaly_detected_out),
    .sticky_status(sticky_status), .anomaly_count(anomaly_count), .hist_full(hist_full)
  );
  typedef struct packed {
    logic [NP-1:0] m;
    logic          a;
    logic [NP-1:0] s;
    logic [CW-1:0] c;
    logic          f;
  } exp_t;
  exp_t          sb[$];
  int            n_tests = 0, n_fail = 0;
  logic [FW-1:0] mh [HD];
  int            mfill, mcnt;
  logic          men [NP];
  logic [WW-1:0] mmask [NP], mval [NP];
  logic [NP-1:0] msticky;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  task automatic model_clear();
    for (int k = 0; k < HD; k++) mh[k] = '0;
    for (int p = 0; p < NP; p++) begin
      men[p] = 1'b0; mmask[p] = '0; mval[p] = '0;
    end
    mfill = 0; mcnt = 0; msticky = '0;
  endtask
  task automatic step(input logic v, input logic [FW-1:0] f, input logic clr, input logic we,
                      input int idx, input logic en, input logic [WW-1:0] mk, input logic [WW-1:0] vl);
    logic [WW-1:0] w;
    logic [NP-1:0] m;
    exp_t          e;
    @(negedge clk);
    flags_valid = v; flags_in = f; status_clr = clr;
    cfg_we = we; cfg_idx = PW'(idx); cfg_en = en; cfg_mask = mk; cfg_value = vl;
    w = '0;
    w[FW-1:0] = f;
    for (int k = 1; k < HD; k++) w[FW*k +: FW] = mh[k-1];
    m = '0;
    for (int p = 0; p < NP; p++)
      if (v && mfill >= HD-1 && men[p]) begin
        m[p] = 1'b1;
        for (int i = 0; i < WW; i++)
          if (mmask[p][i] && w[i] != mval[p][i]) m[p] = 1'b0;
      end
    if (v) begin
      for (int k = HD-1; k > 0; k--) mh[k] = mh[k-1];
      mh[0] = f;
      if (mfill < HD) mfill++;
    end
    if (clr) begin msticky = '0; mcnt = 0; end
    msticky |= m;
    if (|m && mcnt < (1 << CW) - 1) mcnt++;
    if (we && idx < NP) begin men[idx] = en; mmask[idx] = mk; mval[idx] = vl; end
    e.m = m; e.a = |m; e.s = msticky; e.f = (mfill == HD);
`ifdef FLAG_PATTERN_COUNTER_EN
    e.c = CW'(mcnt);
`else
    e.c = '0;
`endif
    sb.push_back(e);
    @(posedge clk);
    #1;
    if (sb.size() == 0) chk("sb_empty", 1, 0);
    else begin
      e = sb.pop_front();
      chk("match_vec", 32'(match_vec), 32'(e.m));
      chk("anomaly", 32'(anomaly_detected_out), 32'(e.a));
      chk("sticky", 32'(sticky_status), 32'(e.s));
      chk("count", 32'(anomaly_count), 32'(e.c));
      chk("hist_full", 32'(hist_full), 32'(e.f));
    end
  endtask
  task automatic smp(input logic [FW-1:0] f);
    step(1'b1, f, 1'b0, 1'b0, 0, 1'b0, '0, '0);
  endtask
  task automatic idle();
    step(1'b0, '0, 1'b0, 1'b0, 0, 1'b0, '0, '0);
  endtask
  task automatic cfg(input int idx, input logic en, input logic [WW-1:0] mk, input logic [WW-1:0] vl);
    step(1'b0, '0, 1'b0, 1'b1, idx, en, mk, vl);
  endtask
  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1; flags_valid = 1'b0; cfg_we = 1'b0; status_clr = 1'b0;
    model_clear();
    @(posedge clk);
    @(posedge clk);
    #1;
    chk("rst_match", 32'(match_vec), 0);
    chk("rst_anomaly", 32'(anomaly_detected_out), 0);
    chk("rst_sticky", 32'(sticky_status), 0);
    chk("rst_count", 32'(anomaly_count), 0);
    chk("rst_full", 32'(hist_full), 0);
    reset = 1'b0;
  endtask
  localparam logic [WW-1:0] LMASK = 16'h0124, LVAL = 16'h0024;
  initial begin
    do_reset();
    cfg(0, 1'b1, LMASK, LVAL);
    smp(4'h0); smp(4'h0); smp(4'h2); smp(4'h4);
    idle();
    do_reset();
    cfg(0, 1'b1, LMASK, LVAL);
    smp(4'h0); smp(4'h2); smp(4'h4); smp(4'h4);
    do_reset();
    cfg(0, 1'b1, LMASK, LVAL);
    for (int i = 0; i < 4; i++) begin
      smp(i == 2 ? 4'h2 : (i == 3 ? 4'h4 : 4'h0));
      repeat (3) idle();
    end
    do_reset();
    cfg(1, 1'b1, '0, '0);
    for (int i = 0; i < 20; i++) smp(4'($urandom_range(0, 15)));
    step(1'b0, '0, 1'b1, 1'b0, 0, 1'b0, '0, '0);
    idle();
    step(1'b1, 4'h3, 1'b1, 1'b0, 0, 1'b0, '0, '0);
    smp(4'h8);
    do_reset();
    cfg(0, 1'b1, LMASK, LVAL);
    smp(4'h0); smp(4'h0); smp(4'h2);
    step(1'b1, 4'h4, 1'b0, 1'b1, 0, 1'b0, LMASK, LVAL);
    smp(4'h4);
    idle();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/flag_pattern_matcher.md
# flag_pattern_matcher

Programmable, multi-pattern anomaly detector for the EX-stage ALU flags, and the parametrised successor to the fixed two-pattern detector. It keeps a configurable-depth history of flag samples and compares the history window against `NUM_PAT` runtime-programmable mask/value patterns. It reports per-pattern match pulses, sticky per-pattern status and an OR'ed anomaly pulse. It also keeps a saturating anomaly event counter for the monitoring/debug path.

## Interface
- `FLAG_W`, 4, flags per sample; bit 0 zero, bit 1 negative, bit 2 carry, bit 3 overflow
- `HIST_DEPTH`, 4, samples in the compare window (≥2); slot 0 newest
- `NUM_PAT`, 4, number of programmable patterns (≥2)
- `CNT_W`, 16, anomaly counter width
- `WIN_W`, derived, FLAG_W*HIST_DEPTH
- `PIDX_W`, derived, $clog2(NUM_PAT)
- `clk`  in  1  sole clock; everything on its rising edge
- `reset`  in  1  synchronous, active-high
- `flags_valid`  in  1  flags_in holds a new sample this cycle
- `flags_in`  in  FLAG_W  current ALU flags
- `cfg_we`  in  1  write one pattern slot
- `cfg_idx`  in  PIDX_W  pattern slot written
- `cfg_en`  in  1  enable bit for the slot
- `cfg_mask`  in  WIN_W  care bits; bit FLAG_W*k+f is flag f of slot k
- `cfg_value`  in  WIN_W  required values under mask
- `status_clr`  in  1  clear sticky status and counter
- `match_vec`  out  NUM_PAT  per-pattern one-cycle match pulse
- `anomaly_detected_out`  out  1  OR of match_vec
- `sticky_status`  out  NUM_PAT  latched matches
- `anomaly_count`  out  CNT_W  saturating count of anomaly cycles
- `hist_full`  out  1  history holds HIST_DEPTH valid samples

## Operation
- History register: HIST_DEPTH×FLAG_W bits, plus fill counter 0..HIST_DEPTH (saturating).
- The history shifts only when `flags_valid`=1. flags_in enters slot 0, slot k moves to k+1, and the oldest sample is dropped. The fill counter increments.
- Match evaluation runs only when `flags_valid`=1. The evaluated window is the post-shift window {history slots 0..HIST_DEPTH-2, flags_in}.
- Pattern p matches when all of these hold:
  - it is enabled
  - the window is full (fill ≥ HIST_DEPTH-1 before the shift)
  - ((window ^ value_p) & mask_p) == 0
- An enabled pattern with mask 0 matches every valid sample once the history is warm.
- Sticky bit p is set on match p. `status_clr` clears all sticky bits and the counter. If a match and `status_clr` occur in the same cycle, the new match wins: the sticky bit is set and the counter is loaded with 1.
- Counter: +1 per cycle in which any pattern matches, not per pattern. It holds at all-ones.
- Config write: `cfg_we` writes en/mask/value into slot cfg_idx. Writes with cfg_idx ≥ NUM_PAT are ignored. A write in the same cycle as a sample does not affect that sample; the new configuration applies from the next sample.
- Reset values:
  - history, fill, match_vec, anomaly_detected_out, sticky_status, anomaly_count, hist_full: 0
  - all pattern slots: disabled, with mask and value 0

## Timing
- Latency is 1 cycle. A sample presented with `flags_valid` at edge N produces match_vec/anomaly_detected_out during the cycle after edge N. Sticky and count update at the same edge.
- match_vec is 0 in every cycle that does not follow a valid sample. Back-to-back valid samples can produce back-to-back pulses.
- hist_full goes high on the edge that accepts the HIST_DEPTH-th sample after reset.
- Reset asserted mid-stream takes priority over all inputs. History, fill and configuration are discarded, and the next HIST_DEPTH samples are needed before any match.
- Outputs are registered, so there is no combinational path from input to output.

## Configuration
- `FLAG_PATTERN_COUNTER_EN`
  - Defined: the anomaly_count counter and its clear/saturation logic are built.
  - Undefined: no counter is built, and anomaly_count is tied to 0. match_vec, sticky_status, anomaly_detected_out and hist_full are unchanged.

## Test plan
- Legacy-equivalent pattern:
  - Program slot 0: mask bit zero@slot2, neg@slot1, carry@slot0; value 0, 1, 1; enabled.
  - Stream 4'h0, 4'h0, 4'h2, 4'h4 with valid.
  - Required: match_vec=4'b0001 and anomaly pulse one cycle after the last sample; sticky=0001; count=1.
- Warm-up: same config, only 4'h0, 4'h2, 4'h4 after reset -> no match, hist_full=0. Then 4'h4 again -> hist_full=1 with no match (slot1=4'h4 has neg=0).
- Gapped stream: repeat the first test with 3 idle cycles between samples -> identical match, and match_vec=0 during idle cycles.
- Saturation: CNT_W=4, enable slot 1 with mask 0, send 20 valid samples -> count stops at 15. Then assert status_clr alone -> count=0 and sticky=0.
- Clear collision: status_clr in the same cycle as a matching sample -> sticky shows the new bit and count=1.
- Config race: cfg_we disables slot 0 in the same cycle as a matching sample -> that sample still matches; an identical next sample does not.
